// File: rtl/flash_read_responder_if.sv
// Avalon-MM read bus between a flash master (music fetch logic) and the flash responder.
interface flash_read_responder_if #(
  parameter int unsigned ADDR_WIDTH       = 23,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTEENABLE_WIDTH = 4
);
  logic                        read;
  logic [ADDR_WIDTH-1:0]       address;
  logic [BYTEENABLE_WIDTH-1:0] byteenable;
  logic                        waitrequest;
  logic                        readdatavalid;
  logic [DATA_WIDTH-1:0]       readdata;

  modport master (
    output read, address, byteenable,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read, address, byteenable,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/flash_read_responder.sv
// Flash stand-in: single-outstanding Avalon-MM read slave with programmable stall,
// fixed read latency, backdoor-loaded word array, served-read counter and protocol check.
module flash_read_responder #(
  parameter int unsigned ADDR_WIDTH       = 23,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTEENABLE_WIDTH = 4,
  parameter int unsigned MEM_AW           = 8,
  parameter int unsigned ACCEPT_DELAY     = 2,
  parameter int unsigned READ_LATENCY     = 3
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  flash_read_responder_if.slave   flash_mem,
  input  logic                    load_en,
  input  logic [MEM_AW-1:0]       load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic [15:0]             reads_served,
  output logic                    protocol_err
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam logic [CNT_W-1:0] STALL_INIT =
    (ACCEPT_DELAY > 0) ? CNT_W'(ACCEPT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] LAT_INIT =
    (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;
  localparam bit NO_STALL = (ACCEPT_DELAY == 0);
  localparam bit SKIP_LAT = (READ_LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    LAT   = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   wait_c;
  logic                   accept_c;
  logic                   err_set_c;
  logic                   enter_valid_c;
  logic [MEM_AW-1:0]      mem_idx_c;
  logic [DATA_WIDTH-1:0]  rd_word_c;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  // Upper address bits alias onto the array; byteenable never affects a read.
  logic unused_bits;
  assign unused_bits = ^{flash_mem.byteenable, flash_mem.address[ADDR_WIDTH-1:MEM_AW]};

  assign mem_idx_c = flash_mem.address[MEM_AW-1:0];
  assign rd_word_c = mem[mem_idx_c];

  // Backdoor load port; array is deliberately not reset.
  always_ff @(posedge clk_50) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // State register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    err_set_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = SKIP_LAT ? VALID : LAT;
          lat_cnt_d = LAT_INIT;
        end else if (flash_mem.read) begin
          state_d     = STALL;
          stall_cnt_d = STALL_INIT;
        end
      end
      STALL: begin
        if (!flash_mem.read) begin
          err_set_c = 1'b1;
          state_d   = IDLE;
        end else if (accept_c) begin
          state_d   = SKIP_LAT ? VALID : LAT;
          lat_cnt_d = LAT_INIT;
        end else begin
          stall_cnt_d = stall_cnt_q - CNT_W'(1);
        end
      end
      LAT: begin
        if (lat_cnt_q == '0) begin
          state_d = VALID;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      VALID:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: waitrequest is held high combinationally throughout reset.
  always_comb begin
    wait_c = 1'b1;
    if (rst_n) begin
      unique case (state_q)
        IDLE:    wait_c = !NO_STALL;
        STALL:   wait_c = (stall_cnt_q != '0);
        default: wait_c = 1'b1;
      endcase
    end
    accept_c = flash_mem.read && !wait_c;
  end

  assign flash_mem.waitrequest = wait_c;
  assign enter_valid_c         = (state_d == VALID);

  // Registered response path; the word is captured at acceptance (read-before-write).
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      data_q                  <= '0;
      flash_mem.readdatavalid <= 1'b0;
      flash_mem.readdata      <= '0;
      reads_served            <= '0;
      protocol_err            <= 1'b0;
    end else begin
      flash_mem.readdatavalid <= enter_valid_c;
      if (accept_c) begin
        data_q <= rd_word_c;
      end
      if (enter_valid_c) begin
        flash_mem.readdata <= accept_c ? rd_word_c : data_q;
        reads_served       <= reads_served + 16'd1;
      end
      if (err_set_c) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Avalon-MM read slave modelling the flash controller end of the bus driven by the music fetch logic.
- Serves single-word, non-burst reads from an internal word array preloaded through a sideband load port.
- Applies a programmable waitrequest stall and a fixed read latency, counts served reads, and flags master protocol violations.
- Used as the flash stand-in for audio-path bring-up and as the bench responder for flash masters.

Parameters:
ADDR_WIDTH, 23, width of flash word address
DATA_WIDTH, 32, width of readdata / load data
BYTEENABLE_WIDTH, 4, width of byteenable (ignored on reads)
MEM_AW, 8, log2 of internal array depth (256 words)
ACCEPT_DELAY, 2, waitrequest-high cycles before a pending read is accepted (0..15)
READ_LATENCY, 3, cycles from acceptance edge to readdatavalid (1..15)

Ports:
clk_50  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
flash_mem_read  input  1  Avalon read request
flash_mem_address  input  ADDR_WIDTH  word address
flash_mem_byteenable  input  BYTEENABLE_WIDTH  ignored; full word always returned
flash_mem_waitrequest  output  1  Avalon waitrequest
flash_mem_readdatavalid  output  1  one-cycle data-valid strobe
flash_mem_readdata  output  DATA_WIDTH  read data
load_en  input  1  backdoor write strobe
load_addr  input  MEM_AW  backdoor write index
load_data  input  DATA_WIDTH  backdoor write data
reads_served  output  16  count of completed reads; wraps at 16'hFFFF -> 0
protocol_err  output  1  sticky violation flag

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, counters 0, readdatavalid=0, readdata=0, reads_served=0, protocol_err=0.
  - waitrequest forced 1 combinationally while rst_n low.
  - Array contents are not reset.
- Acceptance: a read is accepted on the rising edge where flash_mem_read=1 and flash_mem_waitrequest=0. At that edge:
  - latch array[address[MEM_AW-1:0]] into an internal data register (upper address bits alias/wrap);
  - start the latency counter.
- Only one read is outstanding; no pipelining.
- FSM:
  - IDLE: waitrequest = (ACCEPT_DELAY!=0).
    - read=1 and ACCEPT_DELAY==0: accept -> LAT.
    - read=1 and ACCEPT_DELAY>0: stall count=ACCEPT_DELAY-1 -> STALL.
  - STALL: waitrequest = (stall count!=0); count decrements each cycle.
    - When count==0 and read=1: accept -> LAT.
    - read falling to 0 in STALL: set protocol_err -> IDLE, no data returned.
  - LAT: waitrequest=1; counts READ_LATENCY-1 cycles, then -> VALID.
    - READ_LATENCY==1 skips LAT: acceptance -> VALID directly.
  - VALID: registered readdatavalid=1 for exactly one cycle; readdata = latched word; reads_served+1; waitrequest=1 -> IDLE.
- Timing:
  - readdatavalid rises exactly READ_LATENCY edges after the acceptance edge.
  - Back-to-back: next acceptance no earlier than the cycle after VALID, giving min period READ_LATENCY+1+ACCEPT_DELAY cycles per read.
- readdata holds the last returned word when readdatavalid=0; it is never updated except on entry to VALID.
- Master changing address while waitrequest=1 is legal; the address sampled at acceptance wins.
- read=1 during LAT/VALID is treated as a new request, serviced after returning to IDLE; it is not an error.
- Load port:
  - Writes array[load_addr]<=load_data on any cycle, in any state, independent of reads.
  - Same-index load and acceptance on the same edge: read returns the OLD word (read-before-write).
  - A load after acceptance does not alter in-flight data.
- Reset mid-transaction aborts immediately: no readdatavalid issued, reads_served not incremented.
- byteenable has no effect, including 4'b0000.

Test Plan:
- Preload array[5]=32'hDEAD_BEEF; read addr 5 with defaults -> waitrequest high 2 cycles, acceptance on 3rd, readdatavalid exactly 3 edges later with readdata=32'hDEAD_BEEF, reads_served=1.
- ACCEPT_DELAY=0, READ_LATENCY=1; hold read for addrs 0..3 preloaded 0x10..0x13 -> data 0x10,0x11,0x12,0x13 each one cycle after acceptance, period 2 cycles, reads_served=4.
- Read addr 23'h000105 with array[5]=32'h1234_5678 -> returns 32'h1234_5678 (aliasing); byteenable=4'b0000 irrelevant.
- Same-edge load_addr=7 with load_data=32'hAAAA_AAAA and acceptance of addr 7 holding 32'h5555_5555 -> returns 32'h5555_5555; a following read returns 32'hAAAA_AAAA.
- Drop read during STALL -> protocol_err=1 and stays 1, no readdatavalid; assert rst_n=0 during LAT of another read -> outputs at reset values immediately, no strobe, protocol_err cleared.
- Issue 65536 reads -> reads_served wraps to 0.
